// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - requester/master-side signal bundle for i2c_arbiter
//
// Carries the requester request/address/data lanes, the per-requester
// grant/ack/err returns and the link to the shared i2c master.
//   master modport : the arbiter (drives grant/ack/err/m_*/busy)
//   slave  modport : requesters + i2c master (drive req/addr_bus/data_bus/m_done)
interface i2c_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] addr_bus;
  logic [8*NREQ-1:0] data_bus;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [6:0]        m_addr;
  logic [7:0]        m_data;
  logic              m_send;
  logic              m_done;
  logic              busy;

  modport master (
    input  req, addr_bus, data_bus, m_done,
    output grant, ack, err, m_addr, m_data, m_send, busy
  );

  modport slave (
    output req, addr_bus, data_bus, m_done,
    input  grant, ack, err, m_addr, m_data, m_send, busy
  );
endinterface

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c master among NREQ requesters
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : i2c_arbiter_if.master
//           req/addr_bus/data_bus in from requesters, grant/ack/err back,
//           m_addr/m_data/m_send out to the master, m_done in from it, busy.
module i2c_arbiter #(
  parameter int          NREQ           = 4,
  parameter int          PTR_W          = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input logic           clk,
  input logic           reset,
  i2c_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic [23:0]       r_timer;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_err;
  logic [6:0]        r_m_addr;
  logic [7:0]        r_m_data;
  logic              r_m_send;
  logic              r_busy;

  logic              w_sel_valid;
  logic [PTR_W-1:0]  w_sel_idx;
  logic [PTR_W-1:0]  w_scan_idx;
  logic [PTR_W-1:0]  w_next_ptr;

  // Scan ptr, ptr+1, ... wrapping; the first set request wins.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_sel_valid && bus.req[w_scan_idx]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_scan_idx;
      end
    end
  end

  // NREQ need not be a power of two, so wrap explicitly.
  assign w_next_ptr = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_timer  <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_err    <= '0;
      r_m_addr <= '0;
      r_m_data <= '0;
      r_m_send <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_owner  <= w_sel_idx;
            r_grant  <= NREQ'(1) << w_sel_idx;
            r_m_addr <= bus.addr_bus[int'(w_sel_idx)*7 +: 7];
            r_m_data <= bus.data_bus[int'(w_sel_idx)*8 +: 8];
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_m_send <= 1'b1;
          r_timer  <= '0;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          r_m_send <= 1'b0;
          r_timer  <= r_timer + 24'd1;
          // Completion takes priority over a timeout landing on the same cycle.
          if (bus.m_done) begin
            r_ack   <= r_grant;
            r_state <= S_RELEASE;
          end else if (r_timer == TIMEOUT_CYCLES - 24'd1) begin
            r_err   <= r_grant;
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          r_ack   <= '0;
          r_err   <= '0;
          r_grant <= '0;
          r_ptr   <= w_next_ptr;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant  = r_grant;
  assign bus.ack    = r_ack;
  assign bus.err    = r_err;
  assign bus.m_addr = r_m_addr;
  assign bus.m_data = r_m_data;
  assign bus.m_send = r_m_send;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter
module tb_i2c_arbiter;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  i2c_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_arbiter #(
    .NREQ(NREQ),
    .PTR_W(2),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send(output int cyc);
    cyc = 0;
    while (bus.m_send !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    n_total++; if (bus.grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", bus.grant); else n_pass++;
    n_total++; if ({bus.ack, bus.err} !== 8'h00) $display("FAIL reset_ack_err got %h exp 00", {bus.ack, bus.err}); else n_pass++;
    n_total++; if ({bus.m_addr, bus.m_data} !== 15'h0000) $display("FAIL reset_addr_data got %h exp 0000", {bus.m_addr, bus.m_data}); else n_pass++;
    n_total++; if ({bus.m_send, bus.busy} !== 2'b00) $display("FAIL reset_send_busy got %b exp 00", {bus.m_send, bus.busy}); else n_pass++;
    reset = 1'b1;
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    tick();
    n_total++; if ({bus.ack, bus.busy} !== 5'b00000) $display("FAIL idle_done_ignored got %b exp 00000", {bus.ack, bus.busy}); else n_pass++;
  endtask

  task automatic test_single();
    int sends;
    bus.req = 4'b0001;
    bus.addr_bus = 28'h0;
    bus.data_bus = 32'h0;
    bus.addr_bus[6:0] = 7'h50;
    bus.data_bus[7:0] = 8'hA5;
    tick();
    n_total++; if (bus.grant !== 4'b0001) $display("FAIL single_grant got %b exp 0001", bus.grant); else n_pass++;
    n_total++; if (bus.m_addr !== 7'h50) $display("FAIL single_addr got %h exp 50", bus.m_addr); else n_pass++;
    n_total++; if (bus.m_data !== 8'hA5) $display("FAIL single_data got %h exp a5", bus.m_data); else n_pass++;
    n_total++; if ({bus.m_send, bus.busy} !== 2'b01) $display("FAIL single_busy got %b exp 01", {bus.m_send, bus.busy}); else n_pass++;
    tick();
    sends = 0;
    if (bus.m_send === 1'b1) sends++;
    repeat (9) begin
      tick();
      if (bus.m_send === 1'b1) sends++;
    end
    n_total++; if (sends != 1) $display("FAIL single_send_count got %0d exp 1", sends); else n_pass++;
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.req = 4'b0000;
    n_total++; if (bus.ack !== 4'b0001) $display("FAIL single_ack got %b exp 0001", bus.ack); else n_pass++;
    n_total++; if (bus.err !== 4'b0000) $display("FAIL single_err got %b exp 0000", bus.err); else n_pass++;
    tick();
    n_total++; if ({bus.grant, bus.ack, bus.busy} !== 9'b0) $display("FAIL single_release got %b exp 000000000", {bus.grant, bus.ack, bus.busy}); else n_pass++;
    n_total++; if (bus.m_data !== 8'hA5) $display("FAIL single_data_hold got %h exp a5", bus.m_data); else n_pass++;
    // ptr is now 1: with requesters 0 and 1 both asking, 1 must win.
    bus.req = 4'b0011;
    tick();
    n_total++; if (bus.grant !== 4'b0010) $display("FAIL single_ptr_next got %b exp 0010", bus.grant); else n_pass++;
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.req = 4'b0000;
    n_total++; if (bus.ack !== 4'b0010) $display("FAIL single_ptr_ack got %b exp 0010", bus.ack); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] exp_g;
    reset = 1'b0;
    tick();
    bus.req = 4'b1111;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      wait_send(cyc);
      n_total++; if (cyc >= 50) $display("FAIL rr_send_timeout got %0d cycles exp <50", cyc); else n_pass++;
      n_total++; if (bus.grant !== exp_g) $display("FAIL rr_grant_%0d got %b exp %b", i, bus.grant, exp_g); else n_pass++;
      repeat (4) tick();
      bus.m_done = 1'b1;
      tick();
      bus.m_done = 1'b0;
      if (i == 4) bus.req = 4'b0000;
      n_total++; if ({bus.ack, bus.err} !== {exp_g, 4'b0000}) $display("FAIL rr_ack_%0d got %b exp %b", i, {bus.ack, bus.err}, {exp_g, 4'b0000}); else n_pass++;
      tick();
      n_total++; if (bus.ack !== 4'b0000) $display("FAIL rr_ack_once_%0d got %b exp 0000", i, bus.ack); else n_pass++;
    end
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    int n;
    bus.req = 4'b0100;
    wait_send(cyc);
    n_total++; if (cyc >= 50) $display("FAIL to_send_timeout got %0d cycles exp <50", cyc); else n_pass++;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.err === 4'b0000 && n < 100);
    n_total++; if (n != 16) $display("FAIL to_latency got %0d exp 16", n); else n_pass++;
    n_total++; if ({bus.err, bus.ack} !== 8'b0100_0000) $display("FAIL to_err got %b exp 01000000", {bus.err, bus.ack}); else n_pass++;
    bus.req = 4'b0000;
    tick();
    n_total++; if ({bus.err, bus.grant, bus.busy} !== 9'b0) $display("FAIL to_release got %b exp 000000000", {bus.err, bus.grant, bus.busy}); else n_pass++;
    // ptr is now 3: requester 3 beats requester 0.
    bus.req = 4'b1001;
    tick();
    n_total++; if (bus.grant !== 4'b1000) $display("FAIL to_ptr_next got %b exp 1000", bus.grant); else n_pass++;
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.req = 4'b0000;
    n_total++; if (bus.ack !== 4'b1000) $display("FAIL to_ptr_ack got %b exp 1000", bus.ack); else n_pass++;
    tick();
  endtask

  task automatic test_collision();
    int cyc;
    bus.req = 4'b0001;
    wait_send(cyc);
    n_total++; if (cyc >= 50) $display("FAIL col_send_timeout got %0d cycles exp <50", cyc); else n_pass++;
    repeat (15) tick();
    n_total++; if (bus.err !== 4'b0000) $display("FAIL col_early_err got %b exp 0000", bus.err); else n_pass++;
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.req = 4'b0000;
    n_total++; if ({bus.ack, bus.err} !== 8'b0001_0000) $display("FAIL col_ack_wins got %b exp 00010000", {bus.ack, bus.err}); else n_pass++;
    tick();
    n_total++; if ({bus.ack, bus.err} !== 8'b0) $display("FAIL col_after got %b exp 00000000", {bus.ack, bus.err}); else n_pass++;
  endtask

  task automatic test_early_drop();
    bus.req = 4'b0010;
    bus.addr_bus = 28'h0;
    bus.data_bus = 32'h0;
    bus.addr_bus[13:7] = 7'h2A;
    bus.data_bus[15:8] = 8'h3C;
    tick();
    n_total++; if ({bus.grant, bus.m_addr, bus.m_data} !== {4'b0010, 7'h2A, 8'h3C}) $display("FAIL drop_grant got %h exp %h", {bus.grant, bus.m_addr, bus.m_data}, {4'b0010, 7'h2A, 8'h3C}); else n_pass++;
    bus.req = 4'b0000;
    bus.addr_bus[13:7] = 7'h11;
    bus.data_bus[15:8] = 8'hFF;
    tick();
    n_total++; if (bus.m_send !== 1'b1) $display("FAIL drop_send got %b exp 1", bus.m_send); else n_pass++;
    n_total++; if ({bus.m_addr, bus.m_data} !== {7'h2A, 8'h3C}) $display("FAIL drop_data_held got %h exp %h", {bus.m_addr, bus.m_data}, {7'h2A, 8'h3C}); else n_pass++;
    repeat (3) tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    n_total++; if (bus.ack !== 4'b0010) $display("FAIL drop_ack got %b exp 0010", bus.ack); else n_pass++;
    repeat (2) tick();
    n_total++; if ({bus.grant, bus.busy} !== 5'b0) $display("FAIL drop_idle got %b exp 00000", {bus.grant, bus.busy}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    bus.req = 4'b0100;
    wait_send(cyc);
    n_total++; if (cyc >= 50) $display("FAIL rst_send_timeout got %0d cycles exp <50", cyc); else n_pass++;
    n_total++; if (bus.grant !== 4'b0100) $display("FAIL rst_pre_grant got %b exp 0100", bus.grant); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_total++; if ({bus.grant, bus.busy, bus.m_send} !== 6'b0) $display("FAIL rst_async_clear got %b exp 000000", {bus.grant, bus.busy, bus.m_send}); else n_pass++;
    n_total++; if ({bus.ack, bus.err} !== 8'b0) $display("FAIL rst_async_ackerr got %b exp 00000000", {bus.ack, bus.err}); else n_pass++;
    bus.req = 4'b0110;
    bad = 0;
    repeat (20) begin
      tick();
      if ({bus.ack, bus.err, bus.grant} !== 12'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL rst_held_quiet got %0d bad cycles exp 0", bad); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (bus.grant !== 4'b0010) $display("FAIL rst_ptr_zero got %b exp 0010", bus.grant); else n_pass++;
    tick();
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    bus.req = 4'b0000;
    n_total++; if (bus.ack !== 4'b0010) $display("FAIL rst_post_ack got %b exp 0010", bus.ack); else n_pass++;
    tick();
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.addr_bus = 28'h0;
    bus.data_bus = 32'h0;
    bus.m_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_collision();
    test_early_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
